// File: rtl/sodor5_chk_pkg.sv
// sodor5_chk_pkg: R-type decode constants, ALU helpers and checker types
package sodor5_chk_pkg;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ILL
    } alu_op_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_wb_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } chk_state_e;

    function automatic alu_op_e decode_op(input logic [31:0] instr);
        logic [2:0] f3;
        logic [6:0] f7;
        alu_op_e op;
        f3 = instr[14:12];
        f7 = instr[31:25];
        op = ALU_ILL;
        if (instr[6:0] == OPC_OP && f7 == FUNCT7_ALT)
            op = f3 == F3_ADD ? ALU_SUB : f3 == F3_SR ? ALU_SRA : ALU_ILL;
        else if (instr[6:0] == OPC_OP && f7 == FUNCT7_BASE)
            case (f3)
                F3_ADD:  op = ALU_ADD;
                F3_SLL:  op = ALU_SLL;
                F3_SLT:  op = ALU_SLT;
                F3_SLTU: op = ALU_SLTU;
                F3_XOR:  op = ALU_XOR;
                F3_SR:   op = ALU_SRL;
                F3_OR:   op = ALU_OR;
                default: op = ALU_AND;
            endcase
        return op;
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] r;
        sh = b[4:0];
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << sh;
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = $signed(a) >>> sh;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = '0;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/sodor5_chk_fifo.sv
// sodor5_chk_fifo: expected-writeback sync FIFO; push while full only lands if a pop frees a slot the same cycle
module sodor5_chk_fifo
    import sodor5_chk_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  exp_wb_t                  din,
    output exp_wb_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    exp_wb_t     mem [DEPTH];
    logic [AW:0] wp, rp;
    logic        do_push, do_pop;

    assign empty   = wp == rp;
    assign full    = wp == {~rp[AW], rp[AW-1:0]};
    assign count   = wp - rp;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop) rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/sodor5_rtype_wb_checker.sv
// sodor5_rtype_wb_checker: shadow-executes R-type words and checks core writebacks in order; SODOR5_CHK_STOP_ON_ERR_EN latches FAIL on the first error
module sodor5_rtype_wb_checker
    import sodor5_chk_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   init_we,
    input  logic [4:0]             init_addr,
    input  logic [31:0]            init_data,
    input  logic                   start,
    input  logic                   instr_valid,
    input  logic [31:0]            instr,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic [31:0]            wb_data,
    output logic                   mismatch,
    output logic                   overflow,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W-1:0]       chk_count,
    output logic [$clog2(DEPTH):0] pending,
    output logic [1:0]             state
);
    chk_state_e    st, st_nx;
    logic [31:0]   shadow [32];
    alu_op_e       op;
    logic [31:0]   rs1_v, rs2_v, res;
    logic          run, do_dec, wb_chk, pop, hit, wb_err, ovf_now, full, empty;
    exp_wb_t       head;
    logic [1:0]    e_inc;
    logic [CNT_W:0] err_sum, chk_sum;

    assign run     = st == ST_RUN;
    assign op      = decode_op(instr);
    assign rs1_v   = instr[19:15] == 5'd0 ? '0 : shadow[instr[19:15]];
    assign rs2_v   = instr[24:20] == 5'd0 ? '0 : shadow[instr[24:20]];
    assign res     = alu(op, rs1_v, rs2_v);
    assign do_dec  = run && instr_valid && op != ALU_ILL && instr[11:7] != 5'd0;
    assign wb_chk  = run && wb_valid && wb_rd != 5'd0;
    assign pop     = wb_chk && !empty;
    assign hit     = pop && head.rd == wb_rd && head.data == wb_data;
    assign wb_err  = wb_chk && !hit;
    assign ovf_now = do_dec && full && !pop;
    assign e_inc   = {1'b0, wb_err} + {1'b0, ovf_now};
    assign err_sum = {1'b0, err_count} + {{(CNT_W-1){1'b0}}, e_inc};
    assign chk_sum = {1'b0, chk_count} + {{CNT_W{1'b0}}, hit};
    assign state   = st;

    sodor5_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (do_dec),
        .pop     (pop),
        .din     ('{rd: instr[11:7], data: res}),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (pending)
    );

    always_comb begin
        st_nx = st == ST_INIT && start ? ST_RUN : st;
`ifdef SODOR5_CHK_STOP_ON_ERR_EN
        st_nx = run && (wb_err || ovf_now) ? ST_FAIL : st_nx;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st        <= ST_INIT;
            mismatch  <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
            chk_count <= '0;
        end else begin
            st        <= st_nx;
            mismatch  <= wb_err;
            overflow  <= overflow | ovf_now;
            err_count <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
            chk_count <= chk_sum[CNT_W] ? '1 : chk_sum[CNT_W-1:0];
        end
    end

    // shadow survives reset so a preload can be reused across runs
    always_ff @(posedge clk) begin
        if (reset_n && st == ST_INIT && init_we && init_addr != 5'd0) shadow[init_addr] <= init_data;
        else if (reset_n && do_dec) shadow[instr[11:7]] <= res;
    end
endmodule
